// File: rtl/rover_pkg.sv
// Shared definitions for the rover dispatch controller and hospitalROVER:
// FSM state encoding and default location geometry.
package rover_pkg;

  localparam int unsigned DefNumLocs = 8;
  localparam int unsigned DefLocW    = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoving = 2'd1,
    StDwell  = 2'd2
  } state_e;

endpackage

// File: rtl/rover_dispatch_ctrl_if.sv
// Ward-call / rover handshake bundle between the dispatch controller (slave)
// and whatever drives calls and reports the rover position (master).
interface rover_dispatch_ctrl_if import rover_pkg::*; #(
  parameter int unsigned NUM_LOCS = DefNumLocs,
  parameter int unsigned LOC_W    = DefLocW
);
  logic [NUM_LOCS-1:0] call_req;
  logic                estop;
  logic [LOC_W-1:0]    current_loc;
  logic                move_switch;
  logic [LOC_W-1:0]    served_loc;
  logic                arrive;
  logic [NUM_LOCS-1:0] pending;
  logic                busy;

  modport master (
    output call_req, estop, current_loc,
    input  move_switch, served_loc, arrive, pending, busy
  );

  modport slave (
    input  call_req, estop, current_loc,
    output move_switch, served_loc, arrive, pending, busy
  );
endinterface

// File: rtl/rover_dwell_timer.sv
// Dwell counter: loads a start value, counts down on request, flags zero.
module rover_dwell_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rover_dispatch_ctrl.sv
// Latches ward calls and steps the rover via move_switch, holding it at each
// requested location for a fixed dwell before clearing that request.
module rover_dispatch_ctrl import rover_pkg::*; #(
  parameter int unsigned NUM_LOCS     = DefNumLocs,
  parameter int unsigned LOC_W        = DefLocW,
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  rover_dispatch_ctrl_if.slave bus
);

  localparam int unsigned ExtW = 2 ** LOC_W;

  state_e              state_q, state_d;
  logic [NUM_LOCS-1:0] pending_q, pending_d;
  logic [LOC_W-1:0]    svc_loc_q, svc_loc_d;
  logic [LOC_W-1:0]    served_loc_q, served_loc_d;

  logic [ExtW-1:0]     pend_ext;
  logic [ExtW-1:0]     svc_onehot;
  logic [NUM_LOCS-1:0] svc_bit;
  logic                hit;
  logic                done;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]    tmr_cnt;

  // Zero-extend so any current_loc value indexes safely; range check is explicit.
  assign pend_ext   = ExtW'(pending_q);
  assign hit        = (32'(bus.current_loc) < NUM_LOCS) && pend_ext[bus.current_loc];
  assign svc_onehot = {{(ExtW-1){1'b0}}, 1'b1} << svc_loc_q;
  assign svc_bit    = svc_onehot[NUM_LOCS-1:0];
  assign done       = (state_q == StDwell) && tmr_zero && !bus.estop;

  always_comb begin
    // A call for the location being served is absorbed for the whole dwell.
    pending_d = pending_q | (bus.call_req & ~((state_q == StDwell) ? svc_bit : '0));
    if (done) begin
      pending_d = pending_d & ~svc_bit;
    end
  end

  always_comb begin
    state_d      = state_q;
    svc_loc_d    = svc_loc_q;
    served_loc_d = served_loc_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) begin
          if (hit) begin
            state_d   = StDwell;
            tmr_load  = 1'b1;
            svc_loc_d = bus.current_loc;
          end else begin
            state_d = StMoving;
          end
        end
      end
      StMoving: begin
        if (hit) begin
          state_d   = StDwell;
          tmr_load  = 1'b1;
          svc_loc_d = bus.current_loc;
        end
      end
      StDwell: begin
        if (done) begin
          served_loc_d = svc_loc_q;
          state_d      = (pending_d != '0) ? StMoving : StIdle;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.estop) begin
      state_d   = state_q;
      svc_loc_d = svc_loc_q;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      svc_loc_q    <= '0;
      served_loc_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      svc_loc_q    <= svc_loc_d;
      served_loc_q <= served_loc_d;
    end
  end

  rover_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_dwell_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .load_val_i(CNT_W'(DWELL_CYCLES - 1)),
    .dec_i     (tmr_dec),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  logic unused_cnt;
  assign unused_cnt = ^tmr_cnt;

  assign bus.move_switch = (state_q == StMoving) && !hit && !bus.estop;
  assign bus.arrive      = done;
  assign bus.busy        = (state_q != StIdle);
  assign bus.pending     = pending_q;
  assign bus.served_loc  = served_loc_q;

endmodule

// File: tb/tb_rover_dispatch_ctrl.sv
// Directed bench for rover_dispatch_ctrl with a simple rover model that
// advances current_loc by one on every clock where move_switch is high.
module tb_rover_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rover_dispatch_ctrl_if #(.NUM_LOCS(8), .LOC_W(3)) bus ();
  rover_dispatch_ctrl_if #(.NUM_LOCS(6), .LOC_W(3)) bus6 ();

  rover_dispatch_ctrl #(
    .NUM_LOCS(8), .LOC_W(3), .DWELL_CYCLES(4), .CNT_W(8)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  rover_dispatch_ctrl #(
    .NUM_LOCS(6), .LOC_W(3), .DWELL_CYCLES(4), .CNT_W(8)
  ) u_dut6 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus6)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int loc      = 0;
  int cyc, mv;
  bit seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the rover model steps if move_switch was high before the edge.
  task automatic step();
    logic ms;
    ms = bus.move_switch;
    @(posedge clk);
    #1;
    if (ms) loc = (loc + 1) % 8;
    bus.current_loc = 3'(loc);
    #1;
  endtask

  task automatic set_loc(input int l);
    loc = l;
    bus.current_loc = 3'(l);
    #1;
  endtask

  // Counts observed cycles (inclusive of the arrive cycle) and move cycles.
  task automatic wait_arrive(input int budget, output int c, output int m, output bit s);
    c = 0;
    m = 0;
    s = 1'b0;
    while (!s && c < budget) begin
      c++;
      if (bus.move_switch) m++;
      if (bus.arrive) s = 1'b1;
      step();
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.call_req     = 8'hFF;
    bus.estop        = 1'b0;
    bus.current_loc  = 3'd0;
    bus6.call_req    = 6'h3F;
    bus6.estop       = 1'b0;
    bus6.current_loc = 3'd7;
    step();
    step();
    rst_n        = 1'b1;
    bus.call_req = '0;
    bus6.call_req = '0;
    #1;
    check_eq("rst_pending", 32'(bus.pending), 32'h0);
    check_eq("rst_move", 32'(bus.move_switch), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_served", 32'(bus.served_loc), 32'h0);
    check_eq("rst_arrive", 32'(bus.arrive), 32'h0);

    // Single call three locations ahead.
    bus.call_req = 8'h08;
    step();
    bus.call_req = '0;
    wait_arrive(40, cyc, mv, seen);
    check_eq("t2_seen", 32'(seen), 32'h1);
    check_eq("t2_moves", 32'(mv), 32'd3);
    check_eq("t2_cycles", 32'(cyc), 32'd9);
    check_eq("t2_served", 32'(bus.served_loc), 32'd3);
    check_eq("t2_pending", 32'(bus.pending), 32'h0);
    check_eq("t2_busy", 32'(bus.busy), 32'h0);
    check_eq("t2_loc", 32'(loc), 32'd3);

    // Call at the current location: straight into dwell.
    set_loc(2);
    bus.call_req = 8'h04;
    step();
    bus.call_req = '0;
    wait_arrive(40, cyc, mv, seen);
    check_eq("t3_seen", 32'(seen), 32'h1);
    check_eq("t3_moves", 32'(mv), 32'd0);
    check_eq("t3_cycles", 32'(cyc), 32'd5);
    check_eq("t3_served", 32'(bus.served_loc), 32'd2);

    // Two calls; call 1 held through its own dwell must not re-latch.
    set_loc(0);
    bus.call_req = 8'h42;
    step();
    bus.call_req = 8'h02;
    wait_arrive(40, cyc, mv, seen);
    bus.call_req = '0;
    #1;
    check_eq("t4a_cycles", 32'(cyc), 32'd7);
    check_eq("t4a_moves", 32'(mv), 32'd1);
    check_eq("t4a_served", 32'(bus.served_loc), 32'd1);
    check_eq("t4a_pending", 32'(bus.pending), 32'h40);
    check_eq("t4a_busy", 32'(bus.busy), 32'h1);
    wait_arrive(40, cyc, mv, seen);
    check_eq("t4b_cycles", 32'(cyc), 32'd10);
    check_eq("t4b_moves", 32'(mv), 32'd5);
    check_eq("t4b_served", 32'(bus.served_loc), 32'd6);
    check_eq("t4b_pending", 32'(bus.pending), 32'h0);
    check_eq("t4b_busy", 32'(bus.busy), 32'h0);

    // estop while moving, then mid-dwell.
    set_loc(0);
    bus.call_req = 8'h04;
    step();
    bus.call_req = '0;
    step();
    step();
    bus.estop = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_mv_estop", 32'(bus.move_switch), 32'h0);
      if (i == 2) bus.call_req = 8'h20;
      step();
      bus.call_req = '0;
    end
    check_eq("t5_loc_frozen", 32'(loc), 32'd1);
    bus.estop = 1'b0;
    #1;
    check_eq("t5_pending", 32'(bus.pending), 32'h24);
    check_eq("t5_resume", 32'(bus.move_switch), 32'h1);
    step();
    check_eq("t5_hit_stop", 32'(bus.move_switch), 32'h0);
    step();
    step();
    step();
    bus.estop = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_arr_estop", 32'(bus.arrive), 32'h0);
      check_eq("t5_mv_dwell", 32'(bus.move_switch), 32'h0);
      step();
    end
    bus.estop = 1'b0;
    #1;
    wait_arrive(40, cyc, mv, seen);
    check_eq("t5_rest_cycles", 32'(cyc), 32'd2);
    check_eq("t5_served", 32'(bus.served_loc), 32'd2);
    check_eq("t5_pending2", 32'(bus.pending), 32'h20);
    check_eq("t5_busy", 32'(bus.busy), 32'h1);

    // Reset mid-dwell discards everything.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_loc(0);
    bus.call_req = 8'h81;
    step();
    bus.call_req = '0;
    step();
    check_eq("t6_dwell_busy", 32'(bus.busy), 32'h1);
    check_eq("t6_dwell_pend", 32'(bus.pending), 32'h81);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("t6_pending", 32'(bus.pending), 32'h0);
    check_eq("t6_busy", 32'(bus.busy), 32'h0);
    check_eq("t6_move", 32'(bus.move_switch), 32'h0);
    check_eq("t6_served", 32'(bus.served_loc), 32'h0);
    for (int i = 0; i < 6; i++) begin
      check_eq("t6_no_arrive", 32'(bus.arrive), 32'h0);
      step();
    end

    // Six-location instance: locations 6 and 7 are never hits.
    bus6.call_req = 6'h3F;
    step();
    bus6.call_req = '0;
    step();
    check_eq("t6b_busy", 32'(bus6.busy), 32'h1);
    check_eq("t6b_move_l7", 32'(bus6.move_switch), 32'h1);
    bus6.current_loc = 3'd6;
    #1;
    check_eq("t6b_move_l6", 32'(bus6.move_switch), 32'h1);
    bus6.current_loc = 3'd5;
    #1;
    check_eq("t6b_hit_l5", 32'(bus6.move_switch), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
